// File: rtl/cordic_pkg.sv
// Shared types for the iterative shared-adder CORDIC controller and its helpers.
package cordic_pkg;

  typedef enum logic [1:0] {
    OP_COS  = 2'b00,
    OP_SIN  = 2'b01,
    OP_ATAN = 2'b10,
    OP_MAG  = 2'b11
  } op_t;

  // Quadrant pre-shift applied to the angle before rotation
  typedef enum logic [1:0] {
    REG_NONE = 2'b00,
    REG_P90  = 2'b01,
    REG_M90  = 2'b10,
    REG_180  = 2'b11
  } region_t;

  // Adder operand / output mux select; 2'b11 is unused
  typedef enum logic [1:0] {
    VAR_X = 2'b00,
    VAR_Y = 2'b01,
    VAR_Z = 2'b10
  } var_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_ADD,
    ST_ACK,
    ST_FINAL,
    ST_DONE
  } state_t;

  // Request captured when an operation is accepted
  typedef struct packed {
    op_t     op;
    region_t region;
  } req_t;

endpackage

// File: rtl/cordic_quadrant_map.sv
// Combinational (op, region) -> output select / negate for the final result.
// Also used by the pipelined CORDIC, so it carries no state.
module cordic_quadrant_map
  import cordic_pkg::*;
(
  input  logic [1:0] op,
  input  logic [1:0] region,
  output logic [1:0] out_sel,
  output logic       neg_out
);

  // Quadrant fold-back: pick X/Y/Z and sign; vectoring ops ignore region
  always_comb begin
    out_sel = VAR_X;
    neg_out = 1'b0;
    case (op)
      OP_COS: begin
        case (region)
          REG_P90: begin out_sel = VAR_Y; neg_out = 1'b1; end
          REG_M90: out_sel = VAR_Y;
          REG_180: neg_out = 1'b1;
          default: ;
        endcase
      end
      OP_SIN: begin
        case (region)
          REG_NONE: out_sel = VAR_Y;
          REG_M90:  neg_out = 1'b1;
          REG_180:  begin out_sel = VAR_Y; neg_out = 1'b1; end
          default: ;
        endcase
      end
      OP_ATAN: out_sel = VAR_Z;
      default: ;
    endcase
  end

endmodule

// File: rtl/cordic_ctrl_fsm_gen.sv
// Control FSM for the iterative shared-adder CORDIC datapath.
// Each iteration: LOAD, SHIFT, then ADD/ACK for X, Y, Z on the single adder.
module cordic_ctrl_fsm_gen
  import cordic_pkg::*;
#(
  parameter int ITER  = 16,
  parameter int CNT_W = $clog2(ITER)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [1:0]       region,
  input  logic             abort,
  input  logic             ack_out,
  input  logic             add_ready,
  output logic             busy,
  output logic             done,
  output logic             add_start,
  output logic             add_ack,
  output logic             vec_mode,
  output logic [CNT_W-1:0] iter_idx,
  output logic [1:0]       var_sel,
  output logic             sel_init,
  output logic             ld_in,
  output logic             ld_work,
  output logic             ld_shift,
  output logic             ld_x,
  output logic             ld_y,
  output logic             ld_z,
  output logic [1:0]       out_sel,
  output logic             neg_out,
  output logic             ld_out
);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER - 1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] iter_q, iter_nxt;
  var_t             var_q, var_nxt;
  req_t             req_q, req_nxt;
  logic [1:0]       qm_sel;
  logic             qm_neg;

  cordic_quadrant_map u_qmap (
    .op      (req_q.op),
    .region  (req_q.region),
    .out_sel (qm_sel),
    .neg_out (qm_neg)
  );

  assign iter_idx = iter_q;
  assign vec_mode = (req_q.op == OP_ATAN) || (req_q.op == OP_MAG);

  // State, counters and latched request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      var_q   <= VAR_X;
      req_q   <= '0;
    end else begin
      state_q <= state_nxt;
      iter_q  <= iter_nxt;
      var_q   <= var_nxt;
      req_q   <= req_nxt;
    end
  end

  // Next-state, counter update and output decode
  always_comb begin
    state_nxt = state_q;
    iter_nxt  = iter_q;
    var_nxt   = var_q;
    req_nxt   = req_q;
    busy      = 1'b0;
    done      = 1'b0;
    add_start = 1'b0;
    add_ack   = 1'b0;
    var_sel   = 2'b00;
    sel_init  = 1'b0;
    ld_in     = 1'b0;
    ld_work   = 1'b0;
    ld_shift  = 1'b0;
    ld_x      = 1'b0;
    ld_y      = 1'b0;
    ld_z      = 1'b0;
    out_sel   = 2'b00;
    neg_out   = 1'b0;
    ld_out    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ld_in     = 1'b1;
          req_nxt   = '{op: op_t'(op), region: region_t'(region)};
          iter_nxt  = '0;
          var_nxt   = VAR_X;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy      = 1'b1;
        ld_work   = 1'b1;
        sel_init  = (iter_q == '0);
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        ld_shift  = 1'b1;
        state_nxt = ST_ADD;
      end
      ST_ADD: begin
        busy      = 1'b1;
        add_start = 1'b1;
        var_sel   = var_q;
        if (add_ready) begin
          ld_x      = (var_q == VAR_X);
          ld_y      = (var_q == VAR_Y);
          ld_z      = (var_q == VAR_Z);
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        busy    = 1'b1;
        add_ack = 1'b1;
        if (var_q != VAR_Z) begin
          var_nxt   = var_t'(var_q + 2'd1);
          state_nxt = ST_ADD;
        end else begin
          var_nxt = VAR_X;
          if (iter_q == ITER_LAST) begin
            state_nxt = ST_FINAL;
          end else begin
            iter_nxt  = iter_q + CNT_W'(1);
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_FINAL: begin
        busy      = 1'b1;
        ld_out    = 1'b1;
        out_sel   = qm_sel;
        neg_out   = qm_neg;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (ack_out) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Abort wins over add_ready: release the adder, drop its result
    if (abort && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_nxt = ST_IDLE;
      iter_nxt  = '0;
      var_nxt   = VAR_X;
      ld_x      = 1'b0;
      ld_y      = 1'b0;
      ld_z      = 1'b0;
      if (state_q == ST_ADD) add_ack = 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_ctrl_fsm_gen.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares on done / abort. Two DUTs: ITER=16 and ITER=4.
module tb_cordic_ctrl_fsm_gen;
  import cordic_pkg::*;

  typedef struct {
    int         dut;
    bit         aborted;
    int         lat;
    logic [1:0] sel;
    logic       neg;
    logic       vec;
    int         nld;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, abort, ack_out;
  logic [1:0] op, region, start_v, add_ready_v;
  logic [1:0] busy_v, done_v, add_start_v, add_ack_v, vec_v, sel_init_v, ld_in_v;
  logic [1:0] ld_work_v, ld_shift_v, ld_x_v, ld_y_v, ld_z_v, neg_v, ld_out_v;
  logic [1:0][1:0] var_sel_v, out_sel_v;
  logic [3:0] iter16;
  logic [1:0] iter4;
  logic [1:0][5:0] iter_v;
  assign iter_v[0] = {2'b00, iter16};
  assign iter_v[1] = {4'b0000, iter4};

  // Adder model: add_ready comes in the dly-th cycle of add_start
  int   dly = 1;
  logic spur = 1'b0;
  int   rc0 = 0, rc1 = 0;
  always @(posedge clk) begin
    rc0 <= (add_start_v[0] && !add_ready_v[0]) ? rc0 + 1 : 0;
    rc1 <= (add_start_v[1] && !add_ready_v[1]) ? rc1 + 1 : 0;
  end
  assign add_ready_v[0] = spur | (add_start_v[0] & (rc0 >= dly - 1));
  assign add_ready_v[1] = spur | (add_start_v[1] & (rc1 >= dly - 1));

  cordic_ctrl_fsm_gen #(.ITER(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start_v[0]), .op(op), .region(region),
    .abort(abort), .ack_out(ack_out), .add_ready(add_ready_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .add_start(add_start_v[0]), .add_ack(add_ack_v[0]),
    .vec_mode(vec_v[0]), .iter_idx(iter16), .var_sel(var_sel_v[0]), .sel_init(sel_init_v[0]),
    .ld_in(ld_in_v[0]), .ld_work(ld_work_v[0]), .ld_shift(ld_shift_v[0]),
    .ld_x(ld_x_v[0]), .ld_y(ld_y_v[0]), .ld_z(ld_z_v[0]),
    .out_sel(out_sel_v[0]), .neg_out(neg_v[0]), .ld_out(ld_out_v[0])
  );

  cordic_ctrl_fsm_gen #(.ITER(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .op(op), .region(region),
    .abort(abort), .ack_out(ack_out), .add_ready(add_ready_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .add_start(add_start_v[1]), .add_ack(add_ack_v[1]),
    .vec_mode(vec_v[1]), .iter_idx(iter4), .var_sel(var_sel_v[1]), .sel_init(sel_init_v[1]),
    .ld_in(ld_in_v[1]), .ld_work(ld_work_v[1]), .ld_shift(ld_shift_v[1]),
    .ld_x(ld_x_v[1]), .ld_y(ld_y_v[1]), .ld_z(ld_z_v[1]),
    .out_sel(out_sel_v[1]), .neg_out(neg_v[1]), .ld_out(ld_out_v[1])
  );

  int   tests = 0, fails = 0, prot_err = 0, cyc = 0;
  exp_t q[$];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    int   t0[2], nx[2], ny[2], nz[2], nload[2];
    logic [1:0] fsel[2];
    logic fneg[2];
    bit seq_err[2], vec_err[2], done_q[2], ack_q[2], as_q[2], ar_q[2], chk_idle[2];
    bit ab_q;
    ab_q = 0;
    for (int d = 0; d < 2; d++) begin
      t0[d] = 0; nx[d] = 0; ny[d] = 0; nz[d] = 0; nload[d] = 0; fsel[d] = 0; fneg[d] = 0;
      seq_err[d] = 0; vec_err[d] = 0; done_q[d] = 0; ack_q[d] = 0; as_q[d] = 0; ar_q[d] = 0;
      chk_idle[d] = 0;
    end
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int d = 0; d < 2; d++) begin
          done_q[d] = 0; ack_q[d] = 0; as_q[d] = 0; ar_q[d] = 0; chk_idle[d] = 0;
        end
        ab_q = 0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (chk_idle[d]) begin
            chk_idle[d] = 0;
            chk($sformatf("abort_idle%0d", d),
                {busy_v[d], done_v[d], add_start_v[d], iter_v[d]}, 0);
          end
          if (ld_in_v[d]) begin
            t0[d] = cyc; nx[d] = 0; ny[d] = 0; nz[d] = 0; nload[d] = 0;
            seq_err[d] = 0; vec_err[d] = 0;
          end
          if (busy_v[d] && q.size() > 0 && q[0].dut == d && vec_v[d] !== q[0].vec) vec_err[d] = 1;
          if (ld_work_v[d]) begin
            if (iter_v[d] != 6'(nload[d]) || sel_init_v[d] != (nload[d] == 0)) seq_err[d] = 1;
            nload[d]++;
          end
          if ((ld_x_v[d] | ld_y_v[d] | ld_z_v[d]) && !(add_start_v[d] && add_ready_v[d])) prot_err++;
          if (ld_x_v[d] && var_sel_v[d] != 2'b00) prot_err++;
          if (ld_y_v[d] && var_sel_v[d] != 2'b01) prot_err++;
          if (ld_z_v[d] && var_sel_v[d] != 2'b10) prot_err++;
          if (as_q[d] && !ar_q[d] && !ab_q && !add_start_v[d]) prot_err++;
          if (done_q[d] && !ack_q[d] && !done_v[d]) prot_err++;
          if (done_q[d] && ack_q[d] && (done_v[d] || busy_v[d])) prot_err++;
          if (ld_x_v[d]) nx[d]++;
          if (ld_y_v[d]) ny[d]++;
          if (ld_z_v[d]) nz[d]++;
          if (ld_out_v[d]) begin fsel[d] = out_sel_v[d]; fneg[d] = neg_v[d]; end
          if (abort && add_start_v[d]) begin
            chk("abort_add_ack", add_ack_v[d], 1);
            chk("abort_no_ld", {ld_x_v[d], ld_y_v[d], ld_z_v[d]}, 0);
            if (q.size() == 0) begin e = '{dut: -1, aborted: 0, lat: 0, sel: 0, neg: 0, vec: 0, nld: 0}; end
            else e = q.pop_front();
            chk("abort_expected", (e.aborted && e.dut == d), 1);
            chk_idle[d] = 1;
          end
          if (done_v[d] && !done_q[d]) begin
            if (q.size() == 0) begin e = '{dut: -1, aborted: 1, lat: 0, sel: 0, neg: 0, vec: 0, nld: 0}; end
            else e = q.pop_front();
            chk("done_expected", (!e.aborted && e.dut == d), 1);
            chk($sformatf("latency%0d", d), cyc - t0[d], e.lat);
            chk("out_sel", fsel[d], e.sel);
            chk("neg_out", fneg[d], e.neg);
            chk("ld_x_count", nx[d], e.nld);
            chk("ld_y_count", ny[d], e.nld);
            chk("ld_z_count", nz[d], e.nld);
            chk("load_count", nload[d], e.nld);
            chk("iter_seq_err", seq_err[d], 0);
            chk("vec_mode_err", vec_err[d], 0);
          end
          done_q[d] = done_v[d]; ack_q[d] = ack_out;
          as_q[d] = add_start_v[d]; ar_q[d] = add_ready_v[d];
        end
        ab_q = abort;
      end
    end
  end

  task automatic wait_done(input int d, input int maxc);
    int n = 0;
    while (!done_v[d] && n < maxc) begin @(posedge clk); #1; n++; end
    if (!done_v[d]) begin
      tests++; fails++;
      $display("FAIL done_timeout dut%0d: no done within %0d cycles", d, maxc);
    end
  endtask

  task automatic run_op(input int d, input logic [1:0] o, input logic [1:0] r, input int dl,
                        input bit sp, input logic [1:0] es, input logic en, input int lat,
                        input int nld, input int ackd, input bit xs);
    exp_t e;
    dly = dl; spur = sp;
    e = '{dut: d, aborted: 1'b0, lat: lat, sel: es, neg: en, vec: o[1], nld: nld};
    q.push_back(e);
    op = o; region = r; start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v = 2'b00; op = ~o; region = ~r;
    if (xs) begin
      repeat (20) @(posedge clk);
      #1 start_v[d] = 1'b1;
      @(posedge clk); #1;
      start_v = 2'b00;
    end
    wait_done(d, lat + 10);
    repeat (ackd) @(posedge clk);
    #1 ack_out = 1'b1;
    if (xs) start_v[d] = 1'b1;
    @(posedge clk); #1;
    ack_out = 1'b0; start_v = 2'b00; spur = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   n;
    reset = 1'b1; start_v = 2'b00; op = 2'b00; region = 2'b00; abort = 1'b0; ack_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outputs%0d", d),
          {busy_v[d], done_v[d], add_start_v[d], add_ack_v[d], vec_v[d], sel_init_v[d],
           ld_in_v[d], ld_work_v[d], ld_shift_v[d], ld_x_v[d], ld_y_v[d], ld_z_v[d],
           neg_v[d], ld_out_v[d], var_sel_v[d], out_sel_v[d], iter_v[d]}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    //     dut op     region dly spur sel    neg  lat  nld ackd xs
    run_op(0, 2'b00, 2'b00, 1, 0, 2'b00, 1'b0, 130, 16, 0, 0);
    run_op(0, 2'b00, 2'b01, 1, 0, 2'b01, 1'b1, 130, 16, 0, 0);
    run_op(0, 2'b00, 2'b10, 1, 0, 2'b01, 1'b0, 130, 16, 0, 0);
    run_op(0, 2'b00, 2'b11, 1, 1, 2'b00, 1'b1, 130, 16, 0, 0);
    run_op(0, 2'b01, 2'b00, 1, 0, 2'b01, 1'b0, 130, 16, 0, 0);
    run_op(0, 2'b01, 2'b01, 1, 0, 2'b00, 1'b0, 130, 16, 0, 0);
    run_op(0, 2'b01, 2'b10, 1, 0, 2'b00, 1'b1, 130, 16, 0, 0);
    run_op(0, 2'b01, 2'b11, 1, 0, 2'b01, 1'b1, 130, 16, 0, 0);
    run_op(0, 2'b10, 2'b01, 1, 0, 2'b10, 1'b0, 130, 16, 0, 0);
    run_op(0, 2'b11, 2'b10, 1, 0, 2'b00, 1'b0, 130, 16, 0, 0);
    run_op(0, 2'b01, 2'b10, 3, 0, 2'b00, 1'b1, 226, 16, 0, 0);
    run_op(0, 2'b00, 2'b00, 1, 0, 2'b00, 1'b0, 130, 16, 10, 1);
    run_op(1, 2'b10, 2'b11, 1, 0, 2'b10, 1'b0, 34, 4, 0, 0);

    // Abort in the X add of iteration 5, then a full operation
    dly = 1;
    e = '{dut: 0, aborted: 1'b1, lat: 0, sel: 2'b00, neg: 1'b0, vec: 1'b0, nld: 0};
    q.push_back(e);
    op = 2'b00; region = 2'b00; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v = 2'b00;
    n = 0;
    while (!(iter16 == 4'd5 && add_start_v[0]) && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL abort_wait: iteration 5 ADD not reached within 200 cycles");
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    run_op(0, 2'b00, 2'b00, 1, 0, 2'b00, 1'b0, 130, 16, 0, 0);

    // Synchronous reset mid-operation
    op = 2'b00; region = 2'b00; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v = 2'b00;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_midop", {busy_v[0], done_v[0], add_start_v[0], add_ack_v[0], iter16}, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset", {busy_v[0], add_start_v[0], add_ack_v[0]}, 0);

    chk("protocol_errors", prot_err, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
